idma_err_collect: RTL and testbench



---
 rtl/idma_err_collect.sv | 199 +++++++++++++++++++
 tb/tb_idma_err_collect.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_err_collect.sv
// idma_err_collect: gathers error events from several iDMA backend channels,
// queues them, hands them one at a time to the frontend and routes the
// frontend's CONTINUE/ABORT answer back to the channel that raised the error.

package idma_pkg;
    typedef logic [1:0] err_type_t;

    localparam err_type_t BUS_READ  = 2'd0;
    localparam err_type_t BUS_WRITE = 2'd1;
    localparam err_type_t BACKEND   = 2'd2;
    localparam err_type_t ND_MIDEND = 2'd3;

    typedef enum logic {
        CONTINUE = 1'b0,
        ABORT    = 1'b1
    } eh_action_e;

    typedef enum logic {
        NO_ERROR_HANDLING = 1'b0,
        ERROR_HANDLING    = 1'b1
    } error_cap_e;
endpackage

module idma_err_collect #(
    parameter int unsigned          NumChannels = 4,
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          FifoDepth   = 4,
    parameter idma_pkg::error_cap_e ErrorCap    = idma_pkg::ERROR_HANDLING,
    parameter int unsigned          CntWidth    = 16,
    localparam int unsigned         ChW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumChannels-1:0]                  err_valid_i,
    output logic [NumChannels-1:0]                  err_ready_o,
    input  idma_pkg::err_type_t [NumChannels-1:0]   err_type_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0]   err_addr_i,
    output logic                                    rep_valid_o,
    input  logic                                    rep_ready_i,
    output idma_pkg::err_type_t                     rep_type_o,
    output logic [AddrWidth-1:0]                    rep_addr_o,
    output logic [ChW-1:0]                          rep_chan_o,
    input  logic                                    eh_valid_i,
    output logic                                    eh_ready_o,
    input  logic                                    eh_action_i,
    output logic [NumChannels-1:0]                  act_valid_o,
    output logic                                    act_o,
    output logic                                    busy_o,
    output logic [CntWidth-1:0]                     err_count_o
);
    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned FcW  = $clog2(FifoDepth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);
    localparam logic [ChW-1:0]  LastCh  = ChW'(NumChannels - 1);
    localparam bit IsEh = (ErrorCap == idma_pkg::ERROR_HANDLING);

    typedef struct packed {
        idma_pkg::err_type_t  typ;
        logic [AddrWidth-1:0] addr;
        logic [ChW-1:0]       chan;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REPORT   = 2'd1,
        WAIT_ACT = 2'd2,
        ISSUE    = 2'd3
    } state_e;

    state_e                 r_state, w_state_nxt;
    logic                   r_action;
    rec_t                   r_mem [FifoDepth];
    logic [PtrW-1:0]        r_rd_ptr, r_wr_ptr;
    logic [FcW-1:0]         r_fcnt;
    logic [NumChannels-1:0] r_outst;
    logic [ChW-1:0]         r_rr_ptr;
    logic [CntWidth-1:0]    r_err_cnt;

    logic [NumChannels-1:0] w_req, w_gnt, w_set;
    logic [ChW-1:0]         w_gnt_idx;
    logic                   w_gnt_vld, w_push, w_pop, w_issue;
    logic                   w_fifo_full, w_fifo_empty;
    rec_t                   w_head, w_push_rec;

    assign w_fifo_full  = (r_fcnt == FcW'(FifoDepth));
    assign w_fifo_empty = (r_fcnt == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_req        = err_valid_i & ~r_outst;
    assign w_issue      = (r_state == ISSUE);
    assign w_pop        = w_issue;
    // A full FIFO refuses a push even when the head is popped in the same cycle.
    assign w_push       = w_gnt_vld & ~w_fifo_full;

    // Round-robin pick: first requester at or above the pointer, else wrap to the lowest.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (!w_gnt_vld && w_req[i] && (ChW'(i) >= r_rr_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = ChW'(i);
            end
        end
        for (int i = 0; i < NumChannels; i++) begin
            if (!w_gnt_vld && w_req[i] && (ChW'(i) < r_rr_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = ChW'(i);
            end
        end
    end

    // One-hot grant, the record to push and the per-channel handshake.
    always_comb begin
        w_gnt      = '0;
        w_push_rec = '0;
        for (int i = 0; i < NumChannels; i++) begin
            w_gnt[i] = w_gnt_vld && (w_gnt_idx == ChW'(i));
            if (w_gnt[i]) begin
                w_push_rec.typ  = err_type_i[i];
                w_push_rec.addr = err_addr_i[i];
                w_push_rec.chan = ChW'(i);
            end
        end
        w_set       = w_push ? w_gnt : '0;
        err_ready_o = (!rst_i && !w_fifo_full) ? w_gnt : '0;
    end

    // Next-state logic of the report/answer sequencer.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:     if (!w_fifo_empty) w_state_nxt = IsEh ? REPORT : ISSUE;
            REPORT:   if (rep_ready_i) w_state_nxt = WAIT_ACT;
            WAIT_ACT: if (eh_valid_i) w_state_nxt = ISSUE;
            ISSUE:    w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Frontend-facing outputs; report fields read zero when no report is offered.
    always_comb begin
        rep_valid_o = IsEh && (r_state == REPORT) && !rst_i;
        eh_ready_o  = IsEh && (r_state == WAIT_ACT) && !rst_i;
        rep_type_o  = rep_valid_o ? w_head.typ  : '0;
        rep_addr_o  = rep_valid_o ? w_head.addr : '0;
        rep_chan_o  = rep_valid_o ? w_head.chan : '0;
        act_valid_o = '0;
        for (int i = 0; i < NumChannels; i++) begin
            act_valid_o[i] = w_issue && !rst_i && (w_head.chan == ChW'(i));
        end
        act_o       = (w_issue && !rst_i) ? (IsEh ? r_action : 1'b0) : 1'b0;
        busy_o      = !w_fifo_empty || (r_state != IDLE);
        err_count_o = r_err_cnt;
    end

    // State register and the latched frontend answer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_action <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (eh_ready_o && eh_valid_i) r_action <= eh_action_i;
        end
    end

    // Record storage; contents need no reset since the head is only shown when valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) r_mem[r_wr_ptr] <= w_push_rec;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_fcnt   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrW'(1);
            r_fcnt <= r_fcnt + FcW'(w_push) - FcW'(w_pop);
        end
    end

    // Outstanding bits, round-robin pointer and saturating error counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outst   <= '0;
            r_rr_ptr  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_outst <= (r_outst | w_set) & ~act_valid_o;
            if (w_push) begin
                r_rr_ptr <= (w_gnt_idx == LastCh) ? '0 : w_gnt_idx + ChW'(1);
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CntWidth'(1);
            end
        end
    end
endmodule

// File: tb/tb_idma_err_collect.sv
// Bench for idma_err_collect: a timing-rule model checks the default instance
// every cycle; directed literal checks cover a 2-deep/2-bit-counter instance
// and a NO_ERROR_HANDLING instance.
module tb_idma_err_collect;
    import idma_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst = 1'b1;
    logic [3:0]            v_m, v_f, v_n;
    err_type_t [3:0]       etype;
    logic [3:0][31:0]      eaddr;
    logic                  rep_ready, eh_valid, eh_action;

    logic [3:0] rdy_m, av_m, rdy_f, av_f, rdy_n, av_n;
    logic       rv_m, er_m, act_m, busy_m, rv_f, er_f, act_f, busy_f, rv_n, er_n, act_n, busy_n;
    err_type_t  rt_m, rt_f, rt_n;
    logic [31:0] ra_m, ra_f, ra_n;
    logic [1:0] rc_m, rc_f, rc_n;
    logic [15:0] cnt_m, cnt_n;
    logic [1:0] cnt_f;

    idma_err_collect u_dut (
        .clk_i(clk), .rst_i(rst), .err_valid_i(v_m), .err_ready_o(rdy_m),
        .err_type_i(etype), .err_addr_i(eaddr), .rep_valid_o(rv_m), .rep_ready_i(rep_ready),
        .rep_type_o(rt_m), .rep_addr_o(ra_m), .rep_chan_o(rc_m), .eh_valid_i(eh_valid),
        .eh_ready_o(er_m), .eh_action_i(eh_action), .act_valid_o(av_m), .act_o(act_m),
        .busy_o(busy_m), .err_count_o(cnt_m));

    idma_err_collect #(.FifoDepth(2), .CntWidth(2)) u_dut_f2 (
        .clk_i(clk), .rst_i(rst), .err_valid_i(v_f), .err_ready_o(rdy_f),
        .err_type_i(etype), .err_addr_i(eaddr), .rep_valid_o(rv_f), .rep_ready_i(rep_ready),
        .rep_type_o(rt_f), .rep_addr_o(ra_f), .rep_chan_o(rc_f), .eh_valid_i(eh_valid),
        .eh_ready_o(er_f), .eh_action_i(eh_action), .act_valid_o(av_f), .act_o(act_f),
        .busy_o(busy_f), .err_count_o(cnt_f));

    idma_err_collect #(.ErrorCap(NO_ERROR_HANDLING)) u_dut_ne (
        .clk_i(clk), .rst_i(rst), .err_valid_i(v_n), .err_ready_o(rdy_n),
        .err_type_i(etype), .err_addr_i(eaddr), .rep_valid_o(rv_n), .rep_ready_i(rep_ready),
        .rep_type_o(rt_n), .rep_addr_o(ra_n), .rep_chan_o(rc_n), .eh_valid_i(eh_valid),
        .eh_ready_o(er_n), .eh_action_i(eh_action), .act_valid_o(av_n), .act_o(act_n),
        .busy_o(busy_n), .err_count_o(cnt_n));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model of the default instance ----------------
    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        int          chan;
        int          acc_t;
    } mrec_t;

    mrec_t    mq[$];
    bit [3:0] m_out;
    int       m_ptr, m_cnt, m_last, mt;
    bit       m_repd, m_ehd, m_act;

    initial begin
        m_out = '0; m_ptr = 0; m_cnt = 0; m_last = -100; mt = 0;
        m_repd = 0; m_ehd = 0; m_act = 0;
    end

    // Outputs follow from: queue of accepted errors, the accept time of the head,
    // the time of the last action pulse and the two frontend handshakes.
    always @(negedge clk) begin
        int g;
        bit hd, e_rv, e_er, e_pl;
        logic [3:0] e_rdy, e_av;
        mrec_t h, nr;
        mt++;
        if (rst) begin
            chk($sformatf("m_rdy_in_rst@%0d", mt), rdy_m, 4'b0);
            mq.delete();
            m_out = '0; m_ptr = 0; m_cnt = 0; m_last = -100;
            m_repd = 0; m_ehd = 0; m_act = 0;
        end else begin
            g = -1;
            if (mq.size() < 4)
                for (int k = 0; k < 4; k++)
                    if (g < 0 && v_m[(m_ptr + k) % 4] && !m_out[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            e_rdy = (g >= 0) ? (4'b1 << g) : 4'b0;
            hd = (mq.size() > 0);
            e_rv = 0; e_er = 0; e_pl = 0;
            h = '{default: 0};
            if (hd) begin
                h    = mq[0];
                e_pl = m_ehd;
                e_er = m_repd && !m_ehd;
                e_rv = !m_repd && (mt >= ((h.acc_t > m_last) ? h.acc_t : m_last) + 2);
            end
            e_av = e_pl ? (4'b1 << h.chan) : 4'b0;
            chk($sformatf("m_err_ready@%0d", mt), rdy_m, e_rdy);
            chk($sformatf("m_rep_valid@%0d", mt), rv_m, e_rv);
            chk($sformatf("m_rep_type@%0d", mt), rt_m, e_rv ? h.typ : 2'b0);
            chk($sformatf("m_rep_addr@%0d", mt), ra_m, e_rv ? h.addr : 32'b0);
            chk($sformatf("m_rep_chan@%0d", mt), rc_m, e_rv ? h.chan : 0);
            chk($sformatf("m_eh_ready@%0d", mt), er_m, e_er);
            chk($sformatf("m_act_valid@%0d", mt), av_m, e_av);
            chk($sformatf("m_act@%0d", mt), act_m, e_pl ? m_act : 1'b0);
            chk($sformatf("m_busy@%0d", mt), busy_m, hd);
            chk($sformatf("m_count@%0d", mt), cnt_m, m_cnt);
            if (e_pl) begin
                m_out[h.chan] = 0;
                void'(mq.pop_front());
                m_last = mt; m_repd = 0; m_ehd = 0;
            end else begin
                if (e_rv && rep_ready) m_repd = 1;
                if (e_er && eh_valid) begin m_ehd = 1; m_act = eh_action; end
            end
            if (g >= 0) begin
                nr.typ = etype[g]; nr.addr = eaddr[g]; nr.chan = g; nr.acc_t = mt;
                mq.push_back(nr);
                m_out[g] = 1;
                m_ptr = (g + 1) % 4;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int np, acc, npl, nacc;
        int accq[$];
        logic [3:0] seen, amask;

        v_m = '0; v_f = '0; v_n = '0; etype = '0; eaddr = '0;
        rep_ready = 0; eh_valid = 0; eh_action = 0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_err_ready", rdy_m, 4'b0);
        chk("rst_rep_valid", rv_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_count", cnt_m, 16'd0);
        step(); rst = 0;

        // Single error: channel 2, BUS_WRITE, 0x1000, answered ABORT.
        step(); etype[2] = BUS_WRITE; eaddr[2] = 32'h1000; v_m = 4'b0100;
        @(negedge clk); chk("t1_accept", rdy_m, 4'b0100);
        step(); v_m = '0;
        @(negedge clk); chk("t1_no_rep_n1", rv_m, 1'b0);
        step();
        @(negedge clk);
        chk("t1_rep_n2", rv_m, 1'b1);
        chk("t1_rep_chan", rc_m, 2'd2);
        chk("t1_rep_addr", ra_m, 32'h1000);
        chk("t1_rep_type", rt_m, 2'd1);
        step(); rep_ready = 1;
        @(negedge clk); chk("t1_no_ehrdy_at_hs", er_m, 1'b0);
        step(); rep_ready = 0; eh_valid = 1; eh_action = 1;
        @(negedge clk); chk("t1_eh_ready", er_m, 1'b1);
        step(); eh_valid = 0; eh_action = 0;
        @(negedge clk);
        chk("t1_act_valid", av_m, 4'b0100);
        chk("t1_act_abort", act_m, 1'b1);
        chk("t1_count", cnt_m, 16'd1);
        step();
        @(negedge clk);
        chk("t1_act_valid_once", av_m, 4'b0);
        chk("t1_act_idle", act_m, 1'b0);
        chk("t1_busy_done", busy_m, 1'b0);

        // Round robin from a fresh pointer: all four raise at once.
        step(); rst = 1;
        step(); rst = 0;
        step();
        rep_ready = 1; eh_valid = 1; eh_action = 0;
        for (int i = 0; i < 4; i++) begin etype[i] = 2'(i); eaddr[i] = 32'hA0 + 32'(i); end
        v_m = 4'hF;
        np = 0;
        for (int c = 0; c < 60 && np < 4; c++) begin
            @(negedge clk);
            if (c < 4) chk($sformatf("t2_rr_accept%0d", c), rdy_m, 4'b1 << c);
            seen = av_m;
            if (av_m != 4'b0) begin
                chk($sformatf("t2_pulse_order%0d", np), av_m, 4'b1 << np);
                np++;
            end
            step();
            v_m &= ~seen;
        end
        chk("t2_npulses", np, 4);
        rep_ready = 0; eh_valid = 0;

        // Backpressure: report held 10 cycles, must stay stable with no eh_ready.
        step(); etype[3] = BACKEND; eaddr[3] = 32'hDEADBEEF; v_m = 4'b1000;
        @(negedge clk); chk("t3_accept", rdy_m, 4'b1000);
        step(); v_m = '0;
        step();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_rep_held", rv_m, 1'b1);
            chk("t3_rep_addr", ra_m, 32'hDEADBEEF);
            chk("t3_rep_chan", rc_m, 2'd3);
            chk("t3_no_eh_ready", er_m, 1'b0);
            step();
        end
        rep_ready = 1;
        @(negedge clk); chk("t3_hs_no_eh_ready", er_m, 1'b0);
        step(); rep_ready = 0; eh_valid = 1; eh_action = 0;
        @(negedge clk); chk("t3_eh_ready", er_m, 1'b1);
        step(); eh_valid = 0;
        @(negedge clk);
        chk("t3_act_valid", av_m, 4'b1000);
        chk("t3_act_continue", act_m, 1'b0);

        // Reset while waiting for the frontend's answer.
        step(); etype[0] = BUS_READ; eaddr[0] = 32'h55; v_m = 4'b0001;
        @(negedge clk); chk("t4_accept", rdy_m, 4'b0001);
        step(); v_m = '0;
        step(); rep_ready = 1;
        step(); rep_ready = 0;
        @(negedge clk); chk("t4_in_wait_act", er_m, 1'b1);
        step(); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("t4_rep_valid", rv_m, 1'b0);
        chk("t4_eh_ready", er_m, 1'b0);
        chk("t4_act_valid", av_m, 4'b0);
        chk("t4_busy", busy_m, 1'b0);
        chk("t4_count", cnt_m, 16'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            @(negedge clk);
            chk("t4_no_stale_act", av_m, 4'b0);
        end

        // Full FIFO (depth 2, 2-bit counter): frontend stalled, then released.
        step(); rep_ready = 0; eh_valid = 0; v_f = 4'hF;
        acc = 0; amask = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen = rdy_f & v_f;
            acc += $countones(seen);
            amask |= seen;
            step();
            v_f &= ~amask;
        end
        @(negedge clk);
        chk("t5_two_accepts", acc, 2);
        chk("t5_first_two", amask, 4'b0011);
        chk("t5_ready_low", rdy_f, 4'b0);
        chk("t5_busy", busy_f, 1'b1);
        chk("t5_count2", cnt_f, 2'd2);
        step(); rep_ready = 1; eh_valid = 1; eh_action = 0;
        npl = 0;
        for (int c = 0; c < 80 && npl < 4; c++) begin
            @(negedge clk);
            seen = rdy_f & v_f;
            acc += $countones(seen);
            amask |= seen;
            if (av_f != 4'b0) npl++;
            step();
            v_f &= ~amask;
        end
        chk("t5_pulses", npl, 4);
        chk("t5_all_accepted", acc, 4);
        chk("t5_all_mask", amask, 4'hF);
        chk("t5_count_sat", cnt_f, 2'd3);
        step();
        @(negedge clk); chk("t5_drained", busy_f, 1'b0);
        rep_ready = 0; eh_valid = 0;

        // NO_ERROR_HANDLING: three errors on channel 1, frontend pushing ABORT.
        step(); eh_valid = 1; eh_action = 1; etype[1] = BUS_READ; v_n = 4'b0010;
        npl = 0; nacc = 0;
        for (int c = 0; c < 60 && npl < 3; c++) begin
            @(negedge clk);
            chk("t6_rep_valid_low", rv_n, 1'b0);
            chk("t6_eh_ready_low", er_n, 1'b0);
            if (rdy_n[1] && v_n[1]) begin accq.push_back(c); nacc++; end
            if (av_n != 4'b0) begin
                chk("t6_pulse_chan", av_n, 4'b0010);
                chk("t6_act_continue", act_n, 1'b0);
                if (accq.size() > 0) chk("t6_pulse_latency", c - accq.pop_front(), 2);
                else chk("t6_unexpected_pulse", av_n, 4'b0);
                npl++;
            end
            step();
            if (nacc >= 3) v_n = '0;
        end
        chk("t6_npulses", npl, 3);
        chk("t6_count", cnt_n, 16'd3);
        eh_valid = 0; eh_action = 0;

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
